// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall controller bus: hazard-detection inputs from the ID/EX
// pipeline registers and the pipeline write/flush/hold enables going back.
// Optional macro HAZARD_STATS_EN adds the stall_cycles/flush_count counters.
//   slave  : controller side (hazard inputs in, enables out)
//   master : pipeline side (hazard inputs out, enables in)
interface hazard_stall_controller_if;
  logic [4:0]  rs_ID;
  logic [4:0]  rt_ID;
  logic        uses_rt_ID;
  logic [4:0]  rw_ID_EX;
  logic        mem_read_EX_ctrl;
  logic        md_op_ID;
  logic        md_is_div_ID;
  logic        branch_taken_EX;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_hold;
  logic        md_busy;
  logic        md_done;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  modport slave (
    input  rs_ID, rt_ID, uses_rt_ID, rw_ID_EX, mem_read_EX_ctrl,
           md_op_ID, md_is_div_ID, branch_taken_EX,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_hold, md_busy, md_done
`ifdef HAZARD_STATS_EN
    , output stall_cycles, flush_count
`endif
  );

  modport master (
    output rs_ID, rt_ID, uses_rt_ID, rw_ID_EX, mem_read_EX_ctrl,
           md_op_ID, md_is_div_ID, branch_taken_EX,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_hold, md_busy, md_done
`ifdef HAZARD_STATS_EN
    , input stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core. Inserts one-cycle
// load-use bubbles, flushes IF/ID on taken branches and holds EX for the
// full latency of MUL/DIV ops via a two-state FSM with an 8-bit counter.
// Ports:
//   clk   : pipeline clock (rising edge)
//   reset : synchronous, active-high
//   hz    : hazard_stall_controller_if.slave (hazard inputs, enables out)
// Outputs are decoded combinationally from registered state + inputs.
// Optional macro HAZARD_STATS_EN adds stall_cycles / flush_count counters.
module hazard_stall_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  hazard_stall_controller_if.slave  hz
);

  localparam int unsigned CNT_W = 8;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MD_RUN = 1'b1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c;
  logic ex_hold_c, md_busy_c, md_done_c;

  // Load in EX writes a register the ID instruction reads; r0 never hazards.
  assign load_use = hz.mem_read_EX_ctrl && (hz.rw_ID_EX != 5'd0) &&
                    ((hz.rw_ID_EX == hz.rs_ID) ||
                     (hz.uses_rt_ID && (hz.rw_ID_EX == hz.rt_ID)));

  // State and cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and output decode.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pc_write_c      = 1'b1;
    if_id_write_c   = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    ex_hold_c       = 1'b0;
    md_busy_c       = 1'b0;
    md_done_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (hz.branch_taken_EX) begin
          // ID holds a wrong-path instruction: kill it, ignore its hazards.
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end else if (load_use) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
        end else if (hz.md_op_ID) begin
          // Issue cycle counts as the first EX cycle, run cycles follow.
          cnt_d   = hz.md_is_div_ID ? DIV_LOAD : MUL_LOAD;
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        ex_hold_c     = 1'b1;
        md_busy_c     = 1'b1;
        if (cnt_q == '0) begin
          md_done_c = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Reset forces the idle enable pattern, so an aborted op never signals done.
    if (reset) begin
      pc_write_c     = 1'b1;
      if_id_write_c  = 1'b1;
      if_id_flush_c  = 1'b0;
      id_ex_bubble_c = 1'b0;
      ex_hold_c      = 1'b0;
      md_busy_c      = 1'b0;
      md_done_c      = 1'b0;
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.if_id_write  = if_id_write_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_bubble = id_ex_bubble_c;
  assign hz.ex_hold      = ex_hold_c;
  assign hz.md_busy      = md_busy_c;
  assign hz.md_done      = md_done_c;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Saturating stall and flush event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_write_c && (stall_cycles_q != 16'hFFFF))
        stall_cycles_q <= stall_cycles_q + 16'd1;
      if (if_id_flush_c && (flush_count_q != 16'hFFFF))
        flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (default MUL=4, DIV=16).
// Expected output vectors are pushed to a scoreboard queue when each step's
// inputs are driven and popped/compared mid-cycle on the falling edge.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic reset;

  hazard_stall_controller_if hz_if ();

  hazard_stall_controller #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, md_busy, md_done}
  localparam logic [6:0] E_IDLE = 7'b1100000;
  localparam logic [6:0] E_LU   = 7'b0001000;
  localparam logic [6:0] E_BR   = 7'b1111000;
  localparam logic [6:0] E_MD   = 7'b0000110;
  localparam logic [6:0] E_MDD  = 7'b0000111;

  logic [6:0] sb_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic clear_in();
    hz_if.rs_ID            = 5'd0;
    hz_if.rt_ID            = 5'd0;
    hz_if.uses_rt_ID       = 1'b0;
    hz_if.rw_ID_EX         = 5'd0;
    hz_if.mem_read_EX_ctrl = 1'b0;
    hz_if.md_op_ID         = 1'b0;
    hz_if.md_is_div_ID     = 1'b0;
    hz_if.branch_taken_EX  = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rw, input logic [4:0] rs);
    hz_if.mem_read_EX_ctrl = 1'b1;
    hz_if.rw_ID_EX         = rw;
    hz_if.rs_ID            = rs;
  endtask

  // Push expectation, sample mid-cycle, compare, then advance one cycle.
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    logic [6:0] obs;
    sb_q.push_back(exp);
    @(negedge clk);
    n_assert++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed size %0d required >0", tag, sb_q.size());
    end
    e = sb_q.pop_front();
    obs = {hz_if.pc_write, hz_if.if_id_write, hz_if.if_id_flush, hz_if.id_ex_bubble,
           hz_if.ex_hold, hz_if.md_busy, hz_if.md_done};
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
`ifdef HAZARD_STATS_EN
    n_assert++;
    assert (hz_if.stall_cycles === 16'(exp_stall)) else begin
      n_fail++;
      $error("FAIL %s_stall_cycles: observed %0d expected %0d", tag, hz_if.stall_cycles, exp_stall);
    end
    n_assert++;
    assert (hz_if.flush_count === 16'(exp_flush)) else begin
      n_fail++;
      $error("FAIL %s_flush_count: observed %0d expected %0d", tag, hz_if.flush_count, exp_flush);
    end
`endif
    if (reset) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!e[6] && exp_stall < 65535) exp_stall++;
      if (e[4] && exp_flush < 65535) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    @(posedge clk);
    #1;
    // Reset state; reset also masks a live branch/MD request.
    chk("reset_idle", E_IDLE);
    hz_if.branch_taken_EX = 1'b1;
    hz_if.md_op_ID        = 1'b1;
    chk("reset_masks_inputs", E_IDLE);
    clear_in();
    reset = 1'b0;
    chk("idle", E_IDLE);

    // Load-use on rs, then the load leaves EX.
    set_lu(5'd5, 5'd5);
    chk("lu_rs", E_LU);
    clear_in();
    chk("lu_rs_release", E_IDLE);
    // r0 destination never stalls.
    set_lu(5'd0, 5'd0);
    chk("lu_r0", E_IDLE);
    // Different register: no stall.
    set_lu(5'd5, 5'd6);
    chk("lu_miss", E_IDLE);
    clear_in();

    // rt dependency gated by uses_rt_ID.
    set_lu(5'd7, 5'd3);
    hz_if.rt_ID = 5'd7;
    chk("rt_unused", E_IDLE);
    hz_if.uses_rt_ID = 1'b1;
    chk("rt_used", E_LU);
    clear_in();

    // MUL: issue at T, busy T+1..T+3, done T+3; load-use ignored while running.
    hz_if.md_op_ID = 1'b1;
    chk("mul_issue", E_IDLE);
    clear_in();
    chk("mul_run1", E_MD);
    set_lu(5'd9, 5'd9);
    chk("mul_run2_lu_ignored", E_MD);
    clear_in();
    chk("mul_done", E_MDD);
    chk("mul_idle", E_IDLE);

    // DIV: busy T+1..T+15, done T+15.
    hz_if.md_op_ID     = 1'b1;
    hz_if.md_is_div_ID = 1'b1;
    chk("div_issue", E_IDLE);
    clear_in();
    for (int i = 0; i < 14; i++) chk("div_run", E_MD);
    chk("div_done", E_MDD);
    chk("div_idle", E_IDLE);

    // Back-to-back MULs: second issues on the first IDLE cycle.
    hz_if.md_op_ID = 1'b1;
    chk("b2b_issue1", E_IDLE);
    chk("b2b_run1a", E_MD);
    chk("b2b_run1b", E_MD);
    chk("b2b_done1", E_MDD);
    chk("b2b_issue2", E_IDLE);
    clear_in();
    chk("b2b_run2a", E_MD);
    chk("b2b_run2b", E_MD);
    chk("b2b_done2", E_MDD);

    // Load-use pending on the return-to-IDLE cycle is honoured.
    hz_if.md_op_ID = 1'b1;
    chk("lu_after_md_issue", E_IDLE);
    clear_in();
    chk("lu_after_md_run1", E_MD);
    chk("lu_after_md_run2", E_MD);
    chk("lu_after_md_done", E_MDD);
    set_lu(5'd4, 5'd4);
    chk("lu_after_md", E_LU);
    clear_in();
    chk("lu_after_md_release", E_IDLE);

    // DIV aborted by reset at T+6: no done pulse afterwards.
    hz_if.md_op_ID     = 1'b1;
    hz_if.md_is_div_ID = 1'b1;
    chk("abort_issue", E_IDLE);
    clear_in();
    for (int i = 0; i < 5; i++) chk("abort_run", E_MD);
    reset = 1'b1;
    chk("abort_reset", E_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) chk("abort_no_done", E_IDLE);

    // Taken branch beats load-use.
    set_lu(5'd8, 5'd8);
    hz_if.branch_taken_EX = 1'b1;
    chk("br_over_lu", E_BR);
    clear_in();
    // Taken branch suppresses MD issue.
    hz_if.branch_taken_EX = 1'b1;
    hz_if.md_op_ID        = 1'b1;
    chk("br_over_md", E_BR);
    clear_in();
    chk("br_no_md_run", E_IDLE);

    // Load-use beats MD issue; no run starts.
    set_lu(5'd2, 5'd2);
    hz_if.md_op_ID = 1'b1;
    chk("lu_over_md", E_LU);
    clear_in();
    chk("lu_over_md_no_run", E_IDLE);

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d leftover required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS-DLX core; sits beside the forwarding logic and drives the PC/IF-ID/ID-EX write enables.
- Inserts a one-cycle bubble on load-use hazards that forwarding cannot cover.
- Flushes wrong-path instructions on taken branches.
- Holds the EX stage for the full latency of multi-cycle MUL/DIV ops, using an internal FSM and cycle counter.

Parameters:
MUL_CYCLES, 4, EX occupancy in cycles for a multiply (legal range 2..255).
DIV_CYCLES, 16, EX occupancy in cycles for a divide (legal range 2..255; must be >= MUL_CYCLES).

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
rs_ID  input  5  rs field of instruction in ID
rt_ID  input  5  rt field of instruction in ID
uses_rt_ID  input  1  ID instruction reads rt as a source
rw_ID_EX  input  5  destination register of instruction in EX
mem_read_EX_ctrl  input  1  instruction in EX is a load
md_op_ID  input  1  instruction in ID is MUL/DIV
md_is_div_ID  input  1  1 = DIV, 0 = MUL (valid with md_op_ID)
branch_taken_EX  input  1  branch in EX resolved taken this cycle
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID register write enable
if_id_flush  output  1  zero the IF/ID register
id_ex_bubble  output  1  load NOP control into ID/EX
ex_hold  output  1  EX stage and EX/MEM input held (MUL/DIV in progress)
md_busy  output  1  FSM in MD_RUN
md_done  output  1  one-cycle pulse on the final MUL/DIV cycle

Behaviour:
- Reset: state=IDLE, counter=0.
- Reset output values: pc_write=1, if_id_write=1, all other outputs 0.
- A reset asserted during MD_RUN aborts the op; the next cycle is IDLE and no md_done is issued.
- Outputs are decoded combinationally from the registered state plus current inputs.
- States: IDLE, MD_RUN.
- load_use = mem_read_EX_ctrl && rw_ID_EX!=0 && (rw_ID_EX==rs_ID || (uses_rt_ID && rw_ID_EX==rt_ID)).
- IDLE priority, highest first:
  1) branch_taken_EX: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. The load_use stall and the MUL/DIV issue are both suppressed, because the ID instruction is on the wrong path.
  2) load_use: pc_write=0, if_id_write=0, id_ex_bubble=1. Lasts exactly one cycle: the load then advances to MEM and forwarding covers the dependency.
  3) md_op_ID: no stall this cycle and the op issues into ID/EX. Counter loads (md_is_div_ID ? DIV_CYCLES : MUL_CYCLES)-2. Next state is MD_RUN.
  4) Otherwise: all enables 1, flush/bubble/hold 0.
- MD_RUN:
  - Outputs: pc_write=0, if_id_write=0, ex_hold=1, md_busy=1, id_ex_bubble=0.
  - Counter decrements each cycle.
  - When counter==0: md_done=1, next state IDLE.
  - Total EX occupancy = MUL_CYCLES or DIV_CYCLES cycles, counting the issue cycle.
- Inputs ignored in MD_RUN: branch_taken_EX cannot legally assert, since EX holds MUL/DIV. load_use is also ignored.
- A load_use stall or a MUL/DIV issue may be pending in ID on the cycle of return to IDLE; it is evaluated normally on that IDLE cycle.
- A MUL/DIV in ID immediately following another MUL/DIV issues on the first IDLE cycle, giving back-to-back runs with no gap cycle.
- Counter width is 8 bits; no wrap is possible within the legal parameter ranges.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: adds output stall_cycles [15:0].
  - Increments on every cycle with pc_write==0 and reset==0.
  - Saturates at 16'hFFFF; cleared by reset.
  - Also adds output flush_count [15:0], incremented on every cycle with if_id_flush==1, same saturation and reset rules.
- Not defined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- Load-use on rs: mem_read_EX_ctrl=1, rw_ID_EX=5, rs_ID=5 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Same stimulus with rw_ID_EX=0 -> no stall.
- rt dependency gating: rw_ID_EX=7, rt_ID=7 -> no stall with uses_rt_ID=0; one-cycle stall with uses_rt_ID=1.
- MUL, defaults: md_op_ID=1, md_is_div_ID=0 at cycle T -> md_busy=1 and ex_hold=1 on T+1..T+3, md_done=1 on T+3, IDLE at T+4.
- DIV: md_busy=1 for 15 cycles and md_done on T+15. A reset pulse at T+6 -> IDLE at T+7, md_done never asserted, pc_write=1.
- Taken branch with load-use: branch_taken_EX=1 and load_use=1 together -> if_id_flush=1, id_ex_bubble=1, pc_write=1 (no stall). Branch with md_op_ID=1 -> no MD_RUN entry.
- With HAZARD_STATS_EN: one load-use stall plus one default MUL -> stall_cycles=4; after one taken branch, flush_count=1.
